// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- hazard unit for a five-stage (F/D/E/M/W) pipeline.
//
// Produces the stall, flush and operand-forwarding controls for the pipeline
// registers. A two-state FSM (RUN / MEM_WAIT) tracks outstanding data-memory
// accesses. Every control output is combinational from the inputs, so it takes
// effect in the same cycle. The only registers are the FSM state and the
// optional stall counter.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   ra1d, ra2d            Decode-stage source register addresses
//   ra1e, ra2e, wa3e      Execute-stage source and destination addresses
//   wa3m, wa3w            Memory / Writeback destination addresses
//   regwritem, regwritew  register-file write enables in M and W
//   memtorege             the instruction in E is a load
//   pcsrcd/e/m/w          a PC write is in flight in that stage
//   branchtakene          the branch in E is taken
//   mem_req, mem_ready    data-memory request (M stage) and its completion
//   stallf/d/e/m          hold enables for the F, D, E and M pipeline registers
//   flushd/e/w            synchronous clears for the D, E and W pipeline registers
//   forwardae/be          ALU operand select: 00 regfile, 01 W result, 10 M result
//   stall_cnt             number of cycles with stallf high
//
// Configuration
//   HAZARD_PERF_EN        when defined, stall_cnt is a saturating counter of
//                         stallf cycles. When undefined, stall_cnt is tied to 0
//                         and no counter register is built.

module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ra1d,
  input  logic [3:0]       ra2d,
  input  logic [3:0]       ra1e,
  input  logic [3:0]       ra2e,
  input  logic [3:0]       wa3e,
  input  logic [3:0]       wa3m,
  input  logic [3:0]       wa3w,
  input  logic             regwritem,
  input  logic             regwritew,
  input  logic             memtorege,
  input  logic             pcsrcd,
  input  logic             pcsrce,
  input  logic             pcsrcm,
  input  logic             pcsrcw,
  input  logic             branchtakene,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stallf,
  output logic             stalld,
  output logic             stalle,
  output logic             stallm,
  output logic             flushd,
  output logic             flushe,
  output logic             flushw,
  output logic [1:0]       forwardae,
  output logic [1:0]       forwardbe,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t state_q, state_d;
  logic   memwait;
  logic   ldrstall;
  logic   pcpend;

  // The memory wait is taken straight from the handshake, whatever the state,
  // so a miss freezes the pipeline in the very cycle it is seen.
  assign memwait  = mem_req & ~mem_ready;
  assign ldrstall = memtorege & ((wa3e == ra1d) | (wa3e == ra2d));
  assign pcpend   = pcsrcd | pcsrce | pcsrcm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (mem_req && !mem_ready) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready || !mem_req) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Output decode. Reset forces every pipeline register to clear and nothing
  // to hold. While a memory wait is active, the flushes on D and E are
  // suppressed so that the held registers keep their contents (stall wins).
  always_comb begin
    stallf    = 1'b0;
    stalld    = 1'b0;
    stalle    = 1'b0;
    stallm    = 1'b0;
    flushd    = 1'b1;
    flushe    = 1'b1;
    flushw    = 1'b1;
    forwardae = 2'b00;
    forwardbe = 2'b00;
    if (!reset) begin
      stallf = ldrstall | pcpend | memwait;
      stalld = ldrstall | memwait;
      stalle = memwait;
      stallm = memwait;
      flushw = memwait;
      flushd = (pcpend | pcsrcw | branchtakene) & ~memwait;
      flushe = (ldrstall | branchtakene) & ~memwait;

      // The M stage holds the younger result, so it is checked before W.
      if (regwritem && (wa3m == ra1e))      forwardae = 2'b10;
      else if (regwritew && (wa3w == ra1e)) forwardae = 2'b01;

      if (regwritem && (wa3m == ra2e))      forwardbe = 2'b10;
      else if (regwritew && (wa3w == ra2e)) forwardbe = 2'b01;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturates at all-ones, so a long run never wraps back to a small value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         cnt_q <= '0;
    else if (stallf && (cnt_q != '1))  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-002 SHALL have port clk  input  1  pipeline clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports ra1d, ra2d  input  4 each  Decode-stage source register addresses.
REQ-005 SHALL have ports ra1e, ra2e, wa3e  input  4 each  Execute-stage source and destination addresses.
REQ-006 SHALL have ports wa3m, wa3w  input  4 each  Memory- and Writeback-stage destination addresses.
REQ-007 SHALL have ports regwritem, regwritew, memtorege  input  1 each  stage write-enables and load flag.
REQ-008 SHALL have ports pcsrcd, pcsrce, pcsrcm, pcsrcw, branchtakene  input  1 each  PC-write flags per stage and taken branch in E.
REQ-009 SHALL have ports mem_req, mem_ready  input  1 each  data-memory access request (M stage) and completion.
REQ-010 SHALL have ports stallf, stalld, stalle, stallm  output  1 each  hold enables for the F, D, E and M pipeline registers.
REQ-011 SHALL have ports flushd, flushe, flushw  output  1 each  synchronous clear for the D, E and W pipeline registers.
REQ-012 SHALL have ports forwardae, forwardbe  output  2 each  ALU operand select: 00 register file, 01 W result, 10 M result.
REQ-013 SHALL have port stall_cnt  output  CNT_W  count of cycles with stallf high.

Function
REQ-014 SHALL implement FSM states RUN and MEM_WAIT; RUN->MEM_WAIT when mem_req=1 and mem_ready=0; MEM_WAIT->RUN when mem_ready=1 or mem_req=0.
REQ-015 SHALL define memwait = mem_req and not mem_ready in either state (combinational, same cycle).
REQ-016 SHALL drive forwardae=10 if regwritem and wa3m==ra1e, else 01 if regwritew and wa3w==ra1e, else 00; forwardbe identically using ra2e; M has priority over W.
REQ-017 SHALL define ldrstall = memtorege and (wa3e==ra1d or wa3e==ra2d).
REQ-018 SHALL define pcpend = pcsrcd or pcsrce or pcsrcm.
REQ-019 SHALL drive stallf = ldrstall or pcpend or memwait; stalld = ldrstall or memwait; stalle = stallm = flushw = memwait.
REQ-020 SHALL drive flushd = (pcpend or pcsrcw or branchtakene) and not memwait.
REQ-021 SHALL drive flushe = (ldrstall or branchtakene) and not memwait; stall wins over flush on every register.
REQ-022 SHALL keep forwarding outputs valid independent of memwait.
REQ-023 SHALL hold all outputs combinational from inputs and state with zero-cycle latency; only the FSM state and stall_cnt are registered.

Reset
REQ-024 SHALL, while reset=1, force state RUN, stall_cnt=0, all stall outputs 0, flushd=flushe=flushw=1, forwardae=forwardbe=00.
REQ-025 SHALL, on reset asserted mid-MEM_WAIT, return to RUN asynchronously and discard the pending wait.

Configuration
REQ-026 SHALL, with macro HAZARD_PERF_EN defined, increment stall_cnt by 1 each rising edge where stallf=1, saturating at all-ones (no wrap).
REQ-027 SHALL, without HAZARD_PERF_EN, keep the stall_cnt port and drive it constant 0 with no counter register.

Verification
REQ-028 SHALL cover forwarding: regwritem=1, wa3m=3, regwritew=1, wa3w=3, ra1e=3, ra2e=5 -> forwardae=10, forwardbe=00.
REQ-029 SHALL cover load-use: memtorege=1, wa3e=7, ra2d=7 -> stallf=1, stalld=1, flushe=1, flushd=0.
REQ-030 SHALL cover branch: branchtakene=1 -> flushd=1, flushe=1, stallf=0; pcsrcd=1 alone -> stallf=1, flushd=1.
REQ-031 SHALL cover memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> stallf..stallm and flushw high 3 cycles, FSM MEM_WAIT, returns RUN; flushd/flushe 0 throughout even with branchtakene=1.
REQ-032 SHALL cover reset in MEM_WAIT and counter: with HAZARD_PERF_EN, 4 stall cycles -> stall_cnt=4; reset pulse -> stall_cnt=0, state RUN immediately; CNT_W=2 with 5 stalls -> stall_cnt=3.
